// File: rtl/gpu_mem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package gpu_mem_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReadWait,
        StWriteWait,
        StReadRelay,
        StWriteRelay
    } arb_state_t;

    localparam int unsigned MinPtrWidth = 1;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : MinPtrWidth;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority select: first set request bit at or after ptr, wrapping at N.
module rr_picker #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] index
);

    always_comb begin
        logic [PW-1:0] c;
        found = 1'b0;
        index = '0;
        c     = ptr;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[c]) begin
                found = 1'b1;
                index = c;
            end
            c = (c == PW'(N - 1)) ? '0 : c + PW'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory channel between NUM_CONSUMERS requesters.
// Optional memory-response timeout is enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int unsigned NUM_CONSUMERS  = 4,
    parameter int unsigned ADDR_BITS      = 8,
    parameter int unsigned DATA_BITS      = 8
`ifdef DMEM_ARB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
    output logic                     mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address,
    input  logic                     mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data,
    output logic                     mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address,
    output logic [DATA_BITS-1:0]     mem_write_data,
    input  logic                     mem_write_ready
`ifdef DMEM_ARB_TIMEOUT_EN
    , output logic                   timeout_error
`endif
);

    localparam int unsigned PW = ptr_width(NUM_CONSUMERS);

    arb_state_t                 state_q, state_d;
    logic [PW-1:0]              grant_q, grant_d;
    logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
    logic                       rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0]       rd_addr_q, rd_addr_d;
    logic                       wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0]       wr_data_q, wr_data_d;
    logic [NUM_CONSUMERS-1:0]   rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0]   wr_ready_q, wr_ready_d;
    logic [DATA_BITS-1:0]       rd_data_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]       rd_data_d [NUM_CONSUMERS];

    logic [NUM_CONSUMERS-1:0]   pick_req;
    logic                       pick_found;
    logic [PW-1:0]              pick_index;
    logic [PW-1:0]              next_ptr;

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          to_err_q, to_err_d;
    logic          to_hit;

    assign to_hit        = (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_error = to_err_q;
`endif

    // A consumer still holding its ready must not be re-granted until it drops valid.
    assign pick_req = (consumer_read_valid | consumer_write_valid) &
                      ~(rd_ready_q | wr_ready_q);
    assign next_ptr = (grant_q == PW'(NUM_CONSUMERS - 1)) ? '0 : grant_q + PW'(1);

    rr_picker #(
        .N  (NUM_CONSUMERS),
        .PW (PW)
    ) u_rr_picker (
        .req   (pick_req),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .index (pick_index)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_ready_d = rd_ready_q;
        wr_ready_d = wr_ready_q;
        rd_data_d  = rd_data_q;
`ifdef DMEM_ARB_TIMEOUT_EN
        to_cnt_d   = '0;
        to_err_d   = to_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_index;
                    if (consumer_read_valid[pick_index]) begin
                        rd_valid_d = 1'b1;
                        rd_addr_d  = consumer_read_address[pick_index];
                        state_d    = StReadWait;
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = consumer_write_address[pick_index];
                        wr_data_d  = consumer_write_data[pick_index];
                        state_d    = StWriteWait;
                    end
                end
            end
            StReadWait: begin
                if (mem_read_ready) begin
                    rd_data_d[grant_q]  = mem_read_data;
                    rd_ready_d[grant_q] = 1'b1;
                    rd_valid_d          = 1'b0;
                    state_d             = StReadRelay;
                end
`ifdef DMEM_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    rd_data_d[grant_q]  = '0;
                    rd_ready_d[grant_q] = 1'b1;
                    rd_valid_d          = 1'b0;
                    to_err_d            = 1'b1;
                    state_d             = StReadRelay;
                end else begin
                    to_cnt_d = to_cnt_q + CW'(1);
                end
`endif
            end
            StWriteWait: begin
                if (mem_write_ready) begin
                    wr_ready_d[grant_q] = 1'b1;
                    wr_valid_d          = 1'b0;
                    state_d             = StWriteRelay;
                end
`ifdef DMEM_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    wr_ready_d[grant_q] = 1'b1;
                    wr_valid_d          = 1'b0;
                    to_err_d            = 1'b1;
                    state_d             = StWriteRelay;
                end else begin
                    to_cnt_d = to_cnt_q + CW'(1);
                end
`endif
            end
            StReadRelay: begin
                if (!consumer_read_valid[grant_q]) begin
                    rd_ready_d[grant_q] = 1'b0;
                    rr_ptr_d            = next_ptr;
                    state_d             = StIdle;
                end
            end
            StWriteRelay: begin
                if (!consumer_write_valid[grant_q]) begin
                    wr_ready_d[grant_q] = 1'b0;
                    rr_ptr_d            = next_ptr;
                    state_d             = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_ready_q <= '0;
            wr_ready_q <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                rd_data_q[i] <= '0;
            end
`ifdef DMEM_ARB_TIMEOUT_EN
            to_cnt_q   <= '0;
            to_err_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_ready_q <= rd_ready_d;
            wr_ready_q <= wr_ready_d;
            rd_data_q  <= rd_data_d;
`ifdef DMEM_ARB_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            to_err_q   <= to_err_d;
`endif
        end
    end

    assign mem_read_valid       = rd_valid_q;
    assign mem_read_address     = rd_addr_q;
    assign mem_write_valid      = wr_valid_q;
    assign mem_write_address    = wr_addr_q;
    assign mem_write_data       = wr_data_q;
    assign consumer_read_ready  = rd_ready_q;
    assign consumer_write_ready = wr_ready_q;
    assign consumer_read_data   = rd_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (4 consumers, 8-bit address/data).
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] crv = '0;
    logic [7:0] cra [4];
    logic [3:0] crr;
    logic [7:0] crd [4];
    logic [3:0] cwv = '0;
    logic [7:0] cwa [4];
    logic [7:0] cwd [4];
    logic [3:0] cwr;
    logic       mrv;
    logic [7:0] mra;
    logic       mrr = 1'b0;
    logic [7:0] mrd = '0;
    logic       mwv;
    logic [7:0] mwa;
    logic [7:0] mwd;
    logic       mwr = 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
    logic       timeout_error;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .NUM_CONSUMERS (4),
        .ADDR_BITS     (8),
        .DATA_BITS     (8)
`ifdef DMEM_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (crv),
        .consumer_read_address  (cra),
        .consumer_read_ready    (crr),
        .consumer_read_data     (crd),
        .consumer_write_valid   (cwv),
        .consumer_write_address (cwa),
        .consumer_write_data    (cwd),
        .consumer_write_ready   (cwr),
        .mem_read_valid         (mrv),
        .mem_read_address       (mra),
        .mem_read_ready         (mrr),
        .mem_read_data          (mrd),
        .mem_write_valid        (mwv),
        .mem_write_address      (mwa),
        .mem_write_data         (mwd),
        .mem_write_ready        (mwr)
`ifdef DMEM_ARB_TIMEOUT_EN
        , .timeout_error        (timeout_error)
`endif
    );

    // Exclusivity invariants, checked every cycle away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            n_cmp++;
            if ((mrv && mwv) || ($countones({crr, cwr}) > 1)) begin
                n_err++;
                $display("FAIL exclusive: mrv=%b mwv=%b crr=%b cwr=%b want at most one each",
                         mrv, mwv, crr, cwr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++;
        if ({mrv, mwv, crr, cwr} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 0", {mrv, mwv, crr, cwr});
        end
        n_cmp++;
        if ({mra, mwa, mwd} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_mem_bus: got %h want 0", {mra, mwa, mwd});
        end
        n_cmp++;
        if ({crd[0], crd[1], crd[2], crd[3]} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h want 0", {crd[0], crd[1], crd[2], crd[3]});
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if ({mrv, mwv} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_no_req: got %b want 00", {mrv, mwv});
        end
    endtask

    task automatic test_single_read();
        crv[2] = 1'b1;
        cra[2] = 8'h10;
        step();
        n_cmp++;
        if ({mrv, mwv, mra} !== {2'b10, 8'h10}) begin
            n_err++;
            $display("FAIL single_req: got %b/%h want 10/10", {mrv, mwv}, mra);
        end
        mrr = 1'b1;
        mrd = 8'hA5;
        step();
        mrr = 1'b0;
        n_cmp++;
        if ({mrv, crr, crd[2]} !== {1'b0, 4'b0100, 8'hA5}) begin
            n_err++;
            $display("FAIL single_done: got %b %b %h want 0 0100 a5", mrv, crr, crd[2]);
        end
        step();
        n_cmp++;
        if (crr !== 4'b0100) begin
            n_err++;
            $display("FAIL single_hold: got %b want 0100", crr);
        end
        crv[2] = 1'b0;
        step();
        n_cmp++;
        if ({crr, crd[2]} !== {4'b0000, 8'hA5}) begin
            n_err++;
            $display("FAIL single_release: got %b %h want 0000 a5", crr, crd[2]);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] onehot;
        pulse_reset();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) cra[c] = 8'h20 + 8'(c);
            crv = 4'b1111;
            for (int g = 0; g < 4; g++) begin
                step();
                n_cmp++;
                if ({mrv, mra} !== {1'b1, 8'h20 + 8'(g)}) begin
                    n_err++;
                    $display("FAIL rr_grant r%0d g%0d: got %b/%h want 1/%h",
                             r, g, mrv, mra, 8'h20 + 8'(g));
                end
                mrr = 1'b1;
                mrd = 8'h50 + 8'(g) + 8'(r * 16);
                step();
                mrr = 1'b0;
                onehot = 4'b0001 << g;
                n_cmp++;
                if ({crr, crd[g]} !== {onehot, 8'h50 + 8'(g) + 8'(r * 16)}) begin
                    n_err++;
                    $display("FAIL rr_data r%0d g%0d: got %b %h want %b %h", r, g, crr, crd[g],
                             onehot, 8'h50 + 8'(g) + 8'(r * 16));
                end
                crv[g] = 1'b0;
                step();
            end
        end
    endtask

    task automatic test_write_delayed();
        cwv[1] = 1'b1;
        cwa[1] = 8'h07;
        cwd[1] = 8'h3C;
        step();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            n_cmp++;
            if ({mwv, mrv, mwa, mwd, cwr} !== {2'b10, 8'h07, 8'h3C, 4'b0000}) begin
                n_err++;
                $display("FAIL write_wait c%0d: got %b %h %h %b want 10 07 3c 0000",
                         i, {mwv, mrv}, mwa, mwd, cwr);
            end
        end
        step();
        mwr = 1'b1;
        step();
        mwr = 1'b0;
        n_cmp++;
        if ({mwv, cwr} !== {1'b0, 4'b0010}) begin
            n_err++;
            $display("FAIL write_done: got %b %b want 0 0010", mwv, cwr);
        end
        cwv[1] = 1'b0;
        step();
        n_cmp++;
        if (cwr !== 4'b0000) begin
            n_err++;
            $display("FAIL write_release: got %b want 0000", cwr);
        end
    endtask

    task automatic test_read_write_same();
        crv[3] = 1'b1;
        cra[3] = 8'h33;
        cwv[3] = 1'b1;
        cwa[3] = 8'h44;
        cwd[3] = 8'h99;
        step();
        n_cmp++;
        if ({mrv, mwv, mra} !== {2'b10, 8'h33}) begin
            n_err++;
            $display("FAIL rw_read_first: got %b %h want 10 33", {mrv, mwv}, mra);
        end
        mrr = 1'b1;
        mrd = 8'h77;
        step();
        mrr = 1'b0;
        n_cmp++;
        if ({crr, cwr, crd[3]} !== {4'b1000, 4'b0000, 8'h77}) begin
            n_err++;
            $display("FAIL rw_read_done: got %b %b %h want 1000 0000 77", crr, cwr, crd[3]);
        end
        crv[3] = 1'b0;
        step();
        step();
        n_cmp++;
        if ({mrv, mwv, mwa, mwd} !== {2'b01, 8'h44, 8'h99}) begin
            n_err++;
            $display("FAIL rw_write_next: got %b %h %h want 01 44 99", {mrv, mwv}, mwa, mwd);
        end
        mwr = 1'b1;
        step();
        mwr = 1'b0;
        n_cmp++;
        if ({crr, cwr} !== {4'b0000, 4'b1000}) begin
            n_err++;
            $display("FAIL rw_write_done: got %b %b want 0000 1000", crr, cwr);
        end
        cwv[3] = 1'b0;
        step();
        n_cmp++;
        if (crd[0] !== 8'h60) begin
            n_err++;
            $display("FAIL rdata_hold: got %h want 60", crd[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        crv[0] = 1'b1;
        cra[0] = 8'h55;
        step();
        n_cmp++;
        if ({mrv, mra} !== {1'b1, 8'h55}) begin
            n_err++;
            $display("FAIL mid_grant: got %b %h want 1 55", mrv, mra);
        end
        reset = 1'b1;
        crv[0] = 1'b0;
        #1;
        n_cmp++;
        if ({mrv, mwv, mra, crr, cwr, crd[0]} !== 26'h0) begin
            n_err++;
            $display("FAIL mid_async_clear: got %b %h %b %b %h want all 0",
                     {mrv, mwv}, mra, crr, cwr, crd[0]);
        end
        reset = 1'b0;
        mrr = 1'b1;
        mrd = 8'hEE;
        step();
        mrr = 1'b0;
        n_cmp++;
        if ({mrv, crr, crd[0]} !== 13'h0) begin
            n_err++;
            $display("FAIL stray_ready: got %b %b %h want 0 0000 00", mrv, crr, crd[0]);
        end
        step();
    endtask

`ifdef DMEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        crv[1] = 1'b1;
        cra[1] = 8'h66;
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            n_cmp++;
            if ({mrv, crr, timeout_error} !== {1'b1, 4'b0000, 1'b0}) begin
                n_err++;
                $display("FAIL to_wait c%0d: got %b %b %b want 1 0000 0", i, mrv, crr,
                         timeout_error);
            end
        end
        step();
        n_cmp++;
        if ({mrv, crr, crd[1], timeout_error} !== {1'b0, 4'b0010, 8'h00, 1'b1}) begin
            n_err++;
            $display("FAIL to_fire: got %b %b %h %b want 0 0010 00 1", mrv, crr, crd[1],
                     timeout_error);
        end
        crv[1] = 1'b0;
        step();
        step();
        n_cmp++;
        if ({crr, timeout_error} !== {4'b0000, 1'b1}) begin
            n_err++;
            $display("FAIL to_sticky: got %b %b want 0000 1", crr, timeout_error);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < 4; c++) begin
            cra[c] = '0;
            cwa[c] = '0;
            cwd[c] = '0;
        end
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_delayed();
        test_read_write_same();
        test_reset_mid_read();
`ifdef DMEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one data-memory channel between NUM_CONSUMERS per-thread load/store requesters, such as the LSU ports of one or more compute cores.
- Uses round-robin arbitration, one outstanding transaction at a time.
- Consumer side uses the same valid/ready read/write handshake the LSUs already drive. The memory side presents a single read channel and a single write channel.

Parameters:
- NUM_CONSUMERS, 4, number of requesters (≥2).
- ADDR_BITS, 8, data memory address width.
- DATA_BITS, 8, data memory word width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active high.
- consumer_read_valid  in  [NUM_CONSUMERS]  read request per consumer.
- consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  read address per consumer.
- consumer_read_ready  out  [NUM_CONSUMERS]  read complete; data valid.
- consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  returned read data.
- consumer_write_valid  in  [NUM_CONSUMERS]  write request per consumer.
- consumer_write_address  in  [NUM_CONSUMERS][ADDR_BITS]  write address.
- consumer_write_data  in  [NUM_CONSUMERS][DATA_BITS]  write data.
- consumer_write_ready  out  [NUM_CONSUMERS]  write complete.
- mem_read_valid  out  1  memory read request.
- mem_read_address  out  ADDR_BITS  memory read address.
- mem_read_ready  in  1  memory read data valid.
- mem_read_data  in  DATA_BITS  memory read data.
- mem_write_valid  out  1  memory write request.
- mem_write_address  out  ADDR_BITS  memory write address.
- mem_write_data  out  DATA_BITS  memory write data.
- mem_write_ready  in  1  memory write accepted.

Behaviour:
- Reset (async, active high): all outputs 0; state IDLE; rr_ptr=0; grant index 0. Reset mid-transaction aborts it; a late mem_*_ready after reset is ignored.
- Consumer protocol: consumer raises valid and holds valid/address/data until its ready is seen, then drops valid. Ready stays high until valid drops.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- IDLE:
  - Picks the first consumer c, scanning rr_ptr, rr_ptr+1, … (mod NUM_CONSUMERS), with read_valid|write_valid and its ready low.
  - If that consumer asserts both, read wins; write is served on a later grant.
  - Registers grant=c and the address (plus data for writes) into the mem_* outputs.
  - Asserts mem_read_valid → READ_WAIT, or mem_write_valid → WRITE_WAIT, on the next edge.
  - No request: stay in IDLE.
- READ_WAIT: on mem_read_ready, latch mem_read_data into consumer_read_data[grant], set consumer_read_ready[grant]=1, clear mem_read_valid → READ_RELAY. Otherwise hold all outputs stable.
- WRITE_WAIT: on mem_write_ready, set consumer_write_ready[grant]=1, clear mem_write_valid → WRITE_RELAY.
- READ_RELAY / WRITE_RELAY: when the granted consumer's matching valid is low, clear its ready, set rr_ptr=(grant+1) mod NUM_CONSUMERS → IDLE.
- consumer_read_data[c] holds its last value until overwritten.
- Latency:
  - Consumer valid seen at edge k → mem_*_valid high after edge k.
  - mem ready at edge m → consumer ready high after edge m.
  - Arbitration-free turnaround is 1 IDLE cycle between transactions.
  - Minimum read round trip with 0-wait memory is 4 cycles.
- Fairness: a continuously requesting consumer waits at most NUM_CONSUMERS−1 transactions.
- Never more than one mem_*_valid high. Never more than one consumer ready bit high.
- rr_ptr wrap: NUM_CONSUMERS−1 → 0. Non-power-of-two NUM_CONSUMERS is supported.

Optional Feature:
- Macro: DMEM_ARB_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYCLES (default 255) and output timeout_error (1, sticky until reset).
  - A counter runs in READ_WAIT/WRITE_WAIT.
  - After TIMEOUT_CYCLES cycles without mem ready: drop mem_*_valid, complete to the consumer (read data = 0), set timeout_error, and proceed to RELAY.
- When undefined: no counter, no port; WAIT states hold indefinitely.

Decomposition:
- Package gpu_mem_pkg:
  - arb_state_t enum (the five states).
  - Localparam helpers for rr pointer width ($clog2(NUM_CONSUMERS), min 1).
- Sub-module rr_picker: combinational rotate-priority select. Inputs are request vector and rr_ptr; outputs are found and index.
- FSM, mem-side registers and relay logic stay in dmem_arbiter.

Test Plan:
- Single read, memory with 0 wait: consumer 2 reads addr 0x10, mem returns 0xA5 → mem_read_address=0x10, consumer_read_data[2]=0xA5, ready for exactly the cycles until valid drops.
- All 4 consumers assert read at once, rr_ptr=0 → grants in order 0,1,2,3; next simultaneous round starts at 0 again (rr_ptr wrapped to 0).
- Consumer 1 writes 0x3C to addr 0x07 with memory ready delayed 5 cycles → mem_write_* stable for all 5 cycles; consumer_write_ready[1] asserted only after mem_write_ready.
- Consumer 3 asserts read and write simultaneously → read served first, write on its next grant; mem_read_valid and mem_write_valid never high together.
- Reset asserted during READ_WAIT with consumer 0 granted → all outputs 0 immediately; post-reset stray mem_read_ready causes no consumer ready.
- With DMEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never responds → after 8 WAIT cycles consumer ready high with data 0, timeout_error=1 and stays 1.
